// File: rtl/cic_decimator.sv
// cic_decimator
//
// Hogenauer CIC decimator that feeds the ISOP compensator. The block
// integrates every accepted input sample, decimates by R, runs the comb
// chain once per output, and scales away the (R*M)^N gain by keeping the
// top OUT_W bits of the final comb. The result stays on d_out until the
// next output, so a downstream block may sample it on any clock.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   in_valid   d_in carries a sample this cycle
//   d_in       signed IN_W-bit input sample
//   d_out      signed OUT_W-bit decimated output, held between strobes
//   out_valid  one-cycle pulse marking a new d_out

module cic_decimator #(
    parameter int N     = 3,
    parameter int R     = 8,
    parameter int M     = 1,
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  d_in,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    out_valid
);

    localparam int RM_LOG2 = $clog2(R * M);
    localparam int W       = IN_W + N * RM_LOG2;
    localparam int CNT_W   = (R > 1) ? $clog2(R) : 1;

    // Reject parameter sets the datapath cannot support.
    if (R < 2 || R > 64 || (R & (R - 1)) != 0) begin : g_bad_r
        $error("cic_decimator: R must be a power of two in 2..64");
    end
    if (OUT_W > IN_W) begin : g_bad_out_w
        $error("cic_decimator: OUT_W must not exceed IN_W");
    end
    if (N < 1 || N > 6) begin : g_bad_n
        $error("cic_decimator: N must be in 1..6");
    end
    if (M < 1 || M > 2) begin : g_bad_m
        $error("cic_decimator: M must be 1 or 2");
    end

    logic [W-1:0]     integ [N];
    logic [W-1:0]     din_ext;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [W-1:0]     comb_out;
    logic             unused_lsbs;

    assign din_ext = {{(W - IN_W){d_in[IN_W-1]}}, d_in};
    assign tick    = in_valid && (cnt == CNT_W'(R - 1));

    // Integrator cascade. Each stage adds the pre-edge value of the stage
    // before it; overflow wraps on purpose because the combs undo it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (in_valid) begin
            integ[0] <= integ[0] + din_ext;
            for (int k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Decimation counter. R is a power of two, so the natural wrap of the
    // counter gives the modulo-R count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Comb chain. Each stage is a separate generate scope so the
    // combinational subtract chain is not one self-referencing vector.
    for (genvar k = 0; k < N; k++) begin : g_comb
        logic [W-1:0] c_in;
        logic [W-1:0] c_out;
        logic [W-1:0] dly [M];

        if (k == 0) begin : g_first
            assign c_in = integ[N-1];
        end else begin : g_next
            assign c_in = g_comb[k-1].c_out;
        end

        assign c_out = c_in - dly[M-1];

        // Delay line holding this stage's input from the last M ticks.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < M; j++) begin
                    dly[j] <= '0;
                end
            end else if (tick) begin
                dly[0] <= c_in;
                for (int j = 1; j < M; j++) begin
                    dly[j] <= dly[j-1];
                end
            end
        end
    end

    assign comb_out    = g_comb[N-1].c_out;
    assign unused_lsbs = ^comb_out[W-OUT_W-1:0];

    // Output register. Keeping the top bits truncates toward -inf and
    // divides out the full (R*M)^N gain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= tick;
            if (tick) begin
                d_out <= comb_out[W-1 -: OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator
//
// Self-checking bench for cic_decimator. The driver feeds samples and
// pushes each expected output (value and strobe cycle) into a queue; a
// monitor pops and compares whenever out_valid is seen, and otherwise
// checks that d_out is held.

module tb_cic_decimator;

    localparam int N     = 3;
    localparam int R     = 8;
    localparam int M     = 1;
    localparam int IN_W  = 8;
    localparam int OUT_W = 8;
    localparam int W     = IN_W + N * $clog2(R * M);

    typedef logic [W-1:0] acc_t;
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [IN_W-1:0]  d_in;
    logic signed [OUT_W-1:0] d_out;
    logic                    out_valid;

    int   checks;
    int   errors;
    int   cyc;
    int   lastOut;
    exp_t expQ[$];
    int   gotVals[$];
    int   dcSeq[$];
    acc_t xs[$];
    acc_t vs[$];

    cic_decimator #(
        .N(N), .R(R), .M(M), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .d_in(d_in),
        .d_out(d_out),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: the integrator outputs are N-fold running sums of
    // the accepted samples, each stage lagging one sample behind; the combs
    // are N-fold lag-M differences of the decimated sequence. All in W-bit
    // modular arithmetic.
    task automatic modelAccept(input logic signed [IN_W-1:0] x, input int expCyc);
        acc_t lev[];
        acc_t nxt[];
        acc_t y[];
        acc_t run;
        acc_t prev;
        acc_t res;
        logic signed [OUT_W-1:0] o;
        int n;
        exp_t e;
        xs.push_back({{(W - IN_W){x[IN_W-1]}}, x});
        n = xs.size();
        if (n % R == 0) begin
            lev = new[n];
            run = '0;
            for (int i = 0; i < n; i++) begin
                lev[i] = run;
                run    = run + xs[i];
            end
            for (int k = 1; k < N; k++) begin
                nxt = new[n];
                run = '0;
                for (int i = 0; i < n; i++) begin
                    nxt[i] = run;
                    run    = run + lev[i];
                end
                lev = nxt;
            end
            vs.push_back(lev[n-1]);
            y = new[vs.size()];
            for (int j = 0; j < vs.size(); j++) y[j] = vs[j];
            for (int k = 0; k < N; k++) begin
                for (int j = vs.size() - 1; j >= 0; j--) begin
                    prev = (j >= M) ? y[j-M] : '0;
                    y[j] = y[j] - prev;
                end
            end
            res   = y[vs.size()-1];
            o     = res[W-1 -: OUT_W];
            e.cyc = expCyc;
            e.val = int'(o);
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [IN_W-1:0] x);
        @(negedge clk);
        #1;
        in_valid = v;
        d_in     = x;
        if (v) modelAccept(x, cyc + 1);
    endtask

    task automatic resetDut();
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("reset_d_out", int'(d_out), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        xs.delete();
        vs.delete();
        expQ.delete();
        gotVals.delete();
        lastOut = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * R && expQ.size() > 0; i++) begin
            applyStimulus(1'b0, '0);
        end
        applyStimulus(1'b0, '0);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d outputs still missing, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkSteady(input string name, input int val);
        if (gotVals.size() < 10) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_count: got %0d outputs, expected at least 10", name, gotVals.size());
        end else begin
            for (int i = 4; i < 10; i++) checkOutput(name, gotVals[i], val);
        end
    endtask

    // Monitor: pop on every strobe, otherwise d_out must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got out_valid=1 with d_out %0d, expected no strobe", d_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("strobe_cycle", cyc, e.cyc);
                    checkOutput("d_out", int'(d_out), e.val);
                    lastOut = e.val;
                    gotVals.push_back(int'(d_out));
                end
            end else begin
                checkOutput("d_out_held", int'(d_out), lastOut);
            end
        end
    end

    initial begin
        real ph;
        real w;
        int  xi;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        lastOut  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        d_in     = '0;

        // DC positive
        resetDut();
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 8'sd64);
        drain();
        checkSteady("dc_pos", 64);
        dcSeq = gotVals;

        // DC at the negative extreme, integrators wrap
        resetDut();
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, -8'sd128);
        drain();
        checkSteady("dc_neg", -128);

        // Gapped DC stream with junk on d_in during gaps
        resetDut();
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, 8'sd64);
            if (i % 3 == 2) begin
                for (int g = 0; g < 5; g++) applyStimulus(1'b0, IN_W'($urandom));
            end
        end
        drain();
        if (gotVals.size() != dcSeq.size()) begin
            checkOutput("gapped_count", gotVals.size(), dcSeq.size());
        end else begin
            for (int i = 0; i < dcSeq.size(); i++) checkOutput("gapped_seq", gotVals[i], dcSeq[i]);
        end

        // Nyquist tone
        resetDut();
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, (i % 2 == 0) ? 8'sd100 : -8'sd100);
        drain();
        checkSteady("nyquist", 0);

        // Mid-frame reset, then DC
        resetDut();
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 8'sd64);
        resetDut();
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'sd64);
        drain();
        checkOutput("midreset_count", gotVals.size(), 3);

        // Chirp with random gaps
        resetDut();
        ph = 0.0;
        w  = 0.01;
        for (int i = 0; i < 320; i++) begin
            xi = $rtoi(100.0 * $sin(ph));
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, IN_W'($urandom));
            end else begin
                applyStimulus(1'b1, IN_W'(xi));
                ph = ph + w;
                w  = w + 0.002;
            end
        end
        drain();

        // Random full-range samples with random valid
        resetDut();
        for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)), IN_W'($urandom));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
